// File: rtl/bus_source_arbiter_if.sv
// Operand-bus arbitration interface: requester handshake in, grant/select out.
// master: requester/accumulator side; slave: the arbiter.
interface bus_source_arbiter_if;
  logic [4:0] req;
  logic [4:0] last;
  logic       bus_ready;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       beat;

  modport master (
    output req,
    output last,
    output bus_ready,
    input  gnt,
    input  sel,
    input  bus_valid,
    input  beat
  );

  modport slave (
    input  req,
    input  last,
    input  bus_ready,
    output gnt,
    output sel,
    output bus_valid,
    output beat
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter/sequencer for the 5-source 16-bit operand bus.
// Optional feature macro: BUS_ARB_HOLD_LIMIT_EN (MAX_HOLD beat limit per grant,
// enforced only while another requester is waiting).
//
// state | meaning
// IDLE  | no owner, gnt = 0, sel = 0
// OWN   | one requester owns the bus, gnt one-hot, sel = owner index
module bus_source_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_source_arbiter_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [4:0] r_gnt;
  logic [2:0] r_sel;
  logic [2:0] r_ptr;
  logic [3:0] r_beat_cnt;

  logic       w_owner_req;
  logic       w_owner_last;
  logic       w_valid;
  logic       w_beat;
  logic [4:0] w_other;
  logic       w_hold_exp;
  logic       w_end;
  logic [4:0] w_mask;
  logic [2:0] w_base;
  logic [3:0] w_cand;
  logic [2:0] w_win;
  logic       w_found;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("bus_source_arbiter: MAX_HOLD must be in 1..15");
  end

  assign w_owner_req  = |(r_gnt & bus.req);
  assign w_owner_last = |(r_gnt & bus.last);
  assign w_valid      = w_owner_req;
  assign w_beat       = w_valid & bus.bus_ready;
  assign w_other      = bus.req & ~r_gnt;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  assign w_hold_exp = w_beat & (r_beat_cnt >= 4'(MAX_HOLD - 1)) & (|w_other);
`else
  assign w_hold_exp = 1'b0;
`endif

  // Grant ends on a last beat, on abandon, or on hold-limit expiry.
  assign w_end = (w_beat & w_owner_last) | ~w_owner_req | w_hold_exp;

  // Round-robin search from base+1 upward, mod 5. In IDLE all requests compete
  // from ptr; while owning only the other requesters compete from the owner.
  always_comb begin
    w_mask  = (r_state == ST_IDLE) ? bus.req : w_other;
    w_base  = (r_state == ST_IDLE) ? r_ptr : r_sel;
    w_cand  = 4'd0;
    w_win   = 3'd0;
    w_found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w_cand = {1'b0, w_base} + 4'(k);
      if (w_cand > 4'd4) w_cand = w_cand - 4'd5;
      if (!w_found && w_mask[w_cand[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[2:0];
      end
    end
  end

  // Arbitration FSM with registered grant, select, pointer and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 5'b0;
      r_sel      <= 3'd0;
      r_ptr      <= 3'd4;
      r_beat_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_OWN;
            r_gnt      <= 5'b00001 << w_win;
            r_sel      <= w_win;
            r_beat_cnt <= 4'd0;
          end
        end
        ST_OWN: begin
          if (w_end) begin
            r_ptr      <= r_sel;
            r_beat_cnt <= 4'd0;
            if (w_found) begin
              r_gnt <= 5'b00001 << w_win;
              r_sel <= w_win;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 5'b0;
              r_sel   <= 3'd0;
            end
          end else if (w_beat && r_beat_cnt != 4'd15) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 5'b0;
          r_sel   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.bus_valid = w_valid;
  assign bus.beat      = w_beat;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed-vector bench for bus_source_arbiter.
module tb_bus_source_arbiter;

  typedef struct {
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] last;
    logic       rdy;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       beat;
  } vec_t;

  localparam int NVEC = 25;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs [NVEC];

  bus_source_arbiter_if bus_if ();

  bus_source_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] ls, input logic rd);
    @(negedge clk);
    rst_n            = r;
    bus_if.req       = rq;
    bus_if.last      = ls;
    bus_if.bus_ready = rd;
    #1;
  endtask

  initial begin
    logic [4:0] exp_gnt;
    n_checks = 0;
    n_errors = 0;
    rst_n            = 1'b0;
    bus_if.req       = 5'b11111;
    bus_if.last      = 5'b0;
    bus_if.bus_ready = 1'b0;

    //             rst   req       last      rdy   gnt       sel   v     b
    vecs[0]  = '{1'b0, 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'b11111, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'b11111, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 5'b01000, 5'b00000, 1'b1, 5'b10000, 3'd4, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'b01000, 5'b00000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'b01010, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'b01010, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'b01010, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 5'b01010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 5'b01000, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 5'b01000, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 5'b00101, 5'b00001, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    vecs[23] = '{1'b1, 5'b00101, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    vecs[24] = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00001, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst_n, vecs[i].req, vecs[i].last, vecs[i].rdy);
      chk("gnt",   i, 8'(bus_if.gnt),       8'(vecs[i].gnt));
      chk("sel",   i, 8'(bus_if.sel),       8'(vecs[i].sel));
      chk("valid", i, 8'(bus_if.bus_valid), 8'(vecs[i].valid));
      chk("beat",  i, 8'(bus_if.beat),      8'(vecs[i].beat));
    end

    // Hold limit: requester 0 streams without last while requester 2 waits.
    drive(1'b1, 5'b00001, 5'b00000, 1'b1);
    chk("hold_idle_gnt", 0, 8'(bus_if.gnt), 8'h00);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'b00101, 5'b00000, 1'b1);
`ifdef BUS_ARB_HOLD_LIMIT_EN
      exp_gnt = (k < 4) ? 5'b00001 : 5'b00100;
`else
      exp_gnt = 5'b00001;
`endif
      chk("hold_gnt",  k, 8'(bus_if.gnt),  8'(exp_gnt));
      chk("hold_beat", k, 8'(bus_if.beat), 8'h01);
    end

    // Mid-grant reset during owner 4's burst, then arbitration restarts at 0.
    drive(1'b1, 5'b10000, 5'b00000, 1'b1);
    chk("rst_abandon_valid", 0, 8'(bus_if.bus_valid), 8'h00);
    drive(1'b1, 5'b10000, 5'b00000, 1'b1);
    chk("rst_own4_gnt",  0, 8'(bus_if.gnt),  8'h10);
    chk("rst_own4_sel",  0, 8'(bus_if.sel),  8'h04);
    chk("rst_own4_beat", 0, 8'(bus_if.beat), 8'h01);
    drive(1'b0, 5'b11111, 5'b00000, 1'b1);
    chk("rst_pre_gnt", 0, 8'(bus_if.gnt), 8'h10);
    drive(1'b1, 5'b11111, 5'b00000, 1'b1);
    chk("rst_post_gnt",   0, 8'(bus_if.gnt),       8'h00);
    chk("rst_post_sel",   0, 8'(bus_if.sel),       8'h00);
    chk("rst_post_valid", 0, 8'(bus_if.bus_valid), 8'h00);
    drive(1'b1, 5'b11111, 5'b00000, 1'b0);
    chk("rst_regrant_gnt", 0, 8'(bus_if.gnt), 8'h01);
    chk("rst_regrant_sel", 0, 8'(bus_if.sel), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
